param_updown_counter: RTL and testbench



---
 rtl/param_updown_counter.sv | 101 ++++++++++
 tb/tb_param_updown_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with modulus, load, wrap/saturate, carry and overflow.
// Optional prescaler built only when COUNTER_PRESCALE_EN is defined.
module param_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 15,
  parameter int PRESCALE  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             sat_mode,
  input  logic             clear_ovf,
  output logic [WIDTH-1:0] counter_out,
  output logic             carry,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (WIDTH < 2) begin : g_bad_width
    $error("WIDTH must be at least 2");
  end
  if (MAX_VALUE < 0 || MAX_VALUE > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("MAX_VALUE out of range for WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("PRESCALE must be at least 1");
  end

  logic step;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler;

  assign step = enable && (prescaler == PLAST);

  // Prescaler: counts enabled cycles, restarts on load or terminal value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (load) begin
      prescaler <= '0;
    end else if (enable) begin
      if (prescaler == PLAST) prescaler <= '0;
      else prescaler <= prescaler + PW'(1);
    end
  end
`else
  assign step = enable;
`endif

  // Count state: load beats step beats hold; set of overflow beats clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter_out <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (clear_ovf) overflow <= 1'b0;
      if (load) begin
        if (load_value > MAX) begin
          counter_out <= MAX;
          overflow    <= 1'b1;
        end else begin
          counter_out <= load_value;
        end
      end else if (step) begin
        if (up_down) begin
          if (counter_out < MAX) begin
            counter_out <= counter_out + ONE;
          end else begin
            overflow <= 1'b1;
            if (!sat_mode) begin
              counter_out <= '0;
              carry       <= 1'b1;
            end
          end
        end else begin
          if (counter_out > '0) begin
            counter_out <= counter_out - ONE;
          end else begin
            overflow <= 1'b1;
            if (!sat_mode) begin
              counter_out <= MAX;
              carry       <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: table vectors plus reset and
// prescaler sequences.
module tb_param_updown_counter;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic       clock = 1'b1;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_value;
  logic       sat_mode;
  logic       clear_ovf;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       cy_a, cy_b, cy_c;
  logic       ov_a, ov_b, ov_c;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(15), .PRESCALE(1)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .sat_mode(sat_mode),
    .clear_ovf(clear_ovf), .counter_out(cnt_a), .carry(cy_a),
    .overflow(ov_a)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(1)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .sat_mode(sat_mode),
    .clear_ovf(clear_ovf), .counter_out(cnt_b), .carry(cy_b),
    .overflow(ov_b)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(4)) dut_c (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
    .load(load), .load_value(load_value), .sat_mode(sat_mode),
    .clear_ovf(clear_ovf), .counter_out(cnt_c), .carry(cy_c),
    .overflow(ov_c)
  );

  typedef struct packed {
    logic       en;
    logic       ud;
    logic       ld;
    logic [3:0] lv;
    logic       sat;
    logic       clr;
    logic [3:0] cnt;
    logic       cy;
    logic       ov;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pexp[10];

    // rows for dut_b (MAX_VALUE=9): inputs, then expected cnt/carry/ovf
    vt[0]  = '{T, T, T, 4'd8,  F, F, 4'd8, F, F};
    vt[1]  = '{T, T, F, 4'd0,  F, F, 4'd9, F, F};
    vt[2]  = '{T, T, F, 4'd0,  F, F, 4'd0, T, T};
    vt[3]  = '{F, T, F, 4'd0,  F, F, 4'd0, F, T};
    vt[4]  = '{F, T, F, 4'd0,  F, T, 4'd0, F, F};
    vt[5]  = '{T, F, F, 4'd0,  F, F, 4'd9, T, T};
    vt[6]  = '{F, F, F, 4'd0,  F, T, 4'd9, F, F};
    vt[7]  = '{F, F, T, 4'd0,  F, F, 4'd0, F, F};
    vt[8]  = '{T, F, F, 4'd0,  T, F, 4'd0, F, T};
    vt[9]  = '{F, F, F, 4'd0,  F, T, 4'd0, F, F};
    vt[10] = '{T, T, T, 4'd5,  F, F, 4'd5, F, F};
    vt[11] = '{T, T, T, 4'd12, F, F, 4'd9, F, T};
    vt[12] = '{F, T, F, 4'd0,  F, T, 4'd9, F, F};
    vt[13] = '{T, T, F, 4'd0,  F, T, 4'd0, T, T};
    vt[14] = '{F, T, F, 4'd0,  F, T, 4'd0, F, F};
    vt[15] = '{T, T, F, 4'd0,  T, F, 4'd1, F, F};
    vt[16] = '{T, T, T, 4'd9,  T, F, 4'd9, F, F};
    vt[17] = '{T, T, F, 4'd0,  T, F, 4'd9, F, T};
    vt[18] = '{T, F, F, 4'd0,  T, F, 4'd8, F, T};
    vt[19] = '{F, F, F, 4'd0,  F, T, 4'd8, F, F};

    pexp = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2};

    reset      = 1'b0;
    enable     = 1'b1;
    up_down    = 1'b1;
    load       = 1'b0;
    load_value = 4'd0;
    sat_mode   = 1'b0;
    clear_ovf  = 1'b0;

    // reset held across the edge at t=10, released at t=15
    #12;
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_cy", int'(cy_a), 0);
    chk("rst_ov", int'(ov_a), 0);
    #3 reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("count%0d", i), int'(cnt_a), i);
    end

    // asynchronous reset mid-count, no clock edge needed
    #2 reset = 1'b0;
    #1;
    chk("async_rst", int'(cnt_a), 0);
    tick();
    chk("rst_hold", int'(cnt_a), 0);
    #2 reset = 1'b1;
    tick();
    chk("post_rst", int'(cnt_a), 1);

    for (int i = 0; i < 20; i++) begin
      enable     = vt[i].en;
      up_down    = vt[i].ud;
      load       = vt[i].ld;
      load_value = vt[i].lv;
      sat_mode   = vt[i].sat;
      clear_ovf  = vt[i].clr;
      tick();
      chk($sformatf("v%0d_cnt", i), int'(cnt_b), int'(vt[i].cnt));
      chk($sformatf("v%0d_cy", i), int'(cy_b), int'(vt[i].cy));
      chk($sformatf("v%0d_ov", i), int'(ov_b), int'(vt[i].ov));
    end

    enable     = 1'b1;
    up_down    = 1'b1;
    load       = 1'b0;
    load_value = 4'd0;
    sat_mode   = 1'b0;
    clear_ovf  = 1'b0;
    reset      = 1'b0;
    #3 reset   = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("pre_e%0d", i + 1), int'(cnt_c), pexp[i]);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pre_hold%0d", i), int'(cnt_c), 2);
    end
    enable = 1'b1;
    tick();
    chk("pre_late", int'(cnt_c), 2);
    tick();
    chk("pre_step", int'(cnt_c), 3);
    load       = 1'b1;
    load_value = 4'd7;
    tick();
    chk("pre_load", int'(cnt_c), 7);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pre_ld%0d", i), int'(cnt_c), 7);
    end
    tick();
    chk("pre_ld_step", int'(cnt_c), 8);
`else
    tick();
    chk("nopre_1", int'(cnt_c), 1);
    tick();
    chk("nopre_2", int'(cnt_c), 2);
    chk("nopre_b", int'(cnt_b), int'(pexp[9]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
